// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM states and the NOP
// instruction word loaded by the flush muxes.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pipeline_stall_ctrl_timer.sv
// pipe_wait_timer: loadable up-counter with a terminal-count flag (cnt == TERM).
module pipe_wait_timer #(
    parameter int unsigned W    = 8,
    parameter int unsigned TERM = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (inc)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > branch redirect > load-use.
// Optional stall_cycles counter is built when STALL_CNT_EN is defined.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned MEM_TIMEOUT    = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_flush,
    output logic             mem_err
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    ctrl_state_e       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_tc;
    logic [1:0]        pen_cnt;
    logic              pen_tc;
    logic              pen_load, pen_inc;
    logic              mem_block, timeout, frozen;

    // wait_cnt counts frozen cycles; any non-frozen cycle clears it
    pipe_wait_timer #(.W(WAIT_W), .TERM(MEM_TIMEOUT - 1)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (!frozen),
        .load_val ('0),
        .inc      (frozen),
        .cnt      (wait_cnt),
        .tc       (wait_tc)
    );

    // Penalty counts up from 1 to BRANCH_PENALTY, equivalent to a down-count ending at 1
    pipe_wait_timer #(.W(2), .TERM(BRANCH_PENALTY)) u_pen_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (pen_load),
        .load_val (2'd1),
        .inc      (pen_inc),
        .cnt      (pen_cnt),
        .tc       (pen_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_err <= timeout;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        pc_redirect = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        memwb_flush = 1'b0;
        state_nxt   = state;
        pen_load    = 1'b0;
        pen_inc     = 1'b0;

        mem_block = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
        timeout   = mem_block && wait_tc;
        frozen    = mem_block && !timeout;

        if (frozen) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
            if (state == RUN)
                state_nxt = MEM_WAIT;
        end else begin
            case (state)
                MEM_WAIT: state_nxt = RUN;
                REDIRECT: begin
                    ifid_flush = 1'b1;
                    pen_inc    = 1'b1;
                    if (pen_tc)
                        state_nxt = RUN;
                end
                default: begin
                    // ID/EX write is dropped whenever it is flushed
                    if (ex_branch_taken) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        idex_write  = 1'b0;
                        if (BRANCH_PENALTY > 0) begin
                            state_nxt = REDIRECT;
                            pen_load  = 1'b1;
                        end
                    end else if (hz_stall) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        idex_write = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == REDIRECT)
            assert (!ex_branch_taken);
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (!pc_write && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed sequences plus randomized traffic
// against a cycle-level behavioural model (define STALL_CNT_EN to cover the counter).
module tb_pipeline_stall_ctrl;

    localparam int unsigned BP  = 1;
    localparam int unsigned TMO = 8;
    localparam int unsigned CW  = 8;

    logic clk = 1'b0;
    logic rst, hz_stall, ex_branch_taken, mem_req, mem_ready;
    logic pc_write, pc_redirect, ifid_write, ifid_flush;
    logic idex_write, idex_flush, exmem_write, memwb_flush, mem_err;
    logic [CW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    bit m_in_wait;
    int m_waited, m_pen, m_stall;
    bit m_err;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .hz_stall        (hz_stall),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .pc_redirect     (pc_redirect),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_flush      (idex_flush),
        .exmem_write     (exmem_write),
        .memwb_flush     (memwb_flush),
        .mem_err         (mem_err)
`ifdef STALL_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

`ifndef STALL_CNT_EN
    assign stall_cycles = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {pc_write, pc_redirect, ifid_write, ifid_flush,
                idex_write, idex_flush, exmem_write, memwb_flush};
    endfunction

    task automatic model_reset();
        m_in_wait = 0; m_waited = 0; m_pen = 0; m_stall = 0; m_err = 0;
    endtask

    // One clock: drive inputs, check combinational outputs, then the registered ones
    task automatic cycle(input string tag, input bit h, input bit b, input bit r, input bit y);
        logic [7:0] exp;
        bit blk, tmo, frz;
        hz_stall = h; ex_branch_taken = b; mem_req = r; mem_ready = y;
        #2;
        blk = m_in_wait ? !y : (r && !y);
        tmo = blk && (m_waited == TMO - 1);
        frz = blk && !tmo;
        exp = 8'b1010_1010;
        if (frz) begin
            exp = 8'b0000_0001;
            m_waited++;
            m_in_wait = (m_pen == 0);
            m_err = 0;
        end else begin
            m_waited = 0;
            m_err = tmo;
            if (m_in_wait) begin
                m_in_wait = 0;
            end else if (m_pen > 0) begin
                exp[4] = 1'b1;
                m_pen--;
            end else if (b) begin
                exp = 8'b1111_0110;
                m_pen = BP;
            end else if (h) begin
                exp = 8'b0000_0110;
            end
        end
        if (!exp[7] && m_stall < (1 << CW) - 1)
            m_stall++;
        chk({tag, "_outs"}, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
        chk({tag, "_mem_err"}, 32'(mem_err), 32'(m_err));
`ifdef STALL_CNT_EN
        chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
`endif
    endtask

    initial begin
        int pct;
        rst = 1'b1; hz_stall = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outs", 32'(outs()), 32'h0000_00AA);
        chk("reset_mem_err", 32'(mem_err), 32'h0);
        rst = 1'b0;

        // memory wait: 3 stalled cycles then completion
        repeat (3) cycle("t2_wait", 0, 0, 1, 0);
        cycle("t2_done", 0, 0, 1, 1);
        cycle("t2_after", 0, 0, 0, 0);

        // load-use stall alone
        cycle("t4_hz", 1, 0, 0, 0);
        cycle("t4_after", 0, 0, 0, 0);
`ifdef STALL_CNT_EN
        chk("t6_count4", 32'(stall_cycles), 32'd4);
`endif

        // branch overrides simultaneous load-use request, then one penalty cycle
        cycle("t3_br", 1, 1, 0, 0);
        cycle("t3_pen", 1, 0, 0, 0);
        cycle("t3_run", 0, 0, 0, 0);

        // timeout: 7 frozen cycles, forced release, mem_err pulse
        repeat (TMO - 1) cycle("t5_wait", 0, 0, 1, 0);
        cycle("t5_release", 0, 0, 1, 0);
        chk("t5_err_pulse", 32'(mem_err), 32'h1);
        cycle("t5_after", 0, 0, 0, 0);
        chk("t5_err_clear", 32'(mem_err), 32'h0);

        // memory wait during the redirect penalty
        cycle("rd_br", 0, 1, 0, 0);
        repeat (2) cycle("rd_wait", 0, 0, 1, 0);
        cycle("rd_pen", 0, 0, 1, 1);
        cycle("rd_run", 0, 0, 0, 0);

        // async reset in the middle of a wait with wait_cnt=5
        repeat (5) cycle("t1_fill", 0, 0, 1, 0);
        mem_req = 0; rst = 1'b1;
        model_reset();
        #2;
        chk("t1_async_outs", 32'(outs()), 32'h0000_00AA);
        @(posedge clk); #1;
        chk("t1_edge_outs", 32'(outs()), 32'h0000_00AA);
        chk("t1_edge_mem_err", 32'(mem_err), 32'h0);
`ifdef STALL_CNT_EN
        chk("t1_edge_cnt", 32'(stall_cycles), 32'h0);
`endif
        rst = 1'b0;

`ifdef STALL_CNT_EN
        // saturation of the stall counter
        repeat ((1 << CW) + 4) cycle("t6_sat", 1, 0, 0, 0);
        chk("t6_sat_ones", 32'(stall_cycles), 32'((1 << CW) - 1));
`endif

        for (int i = 0; i < 2000; i++) begin
            bit h, b, r, y;
            pct = ((i / 400) % 2 == 0) ? 70 : 8;
            h = ($urandom % 4) == 0;
            b = (m_pen == 0) && (($urandom % 6) == 0);
            r = ($urandom % 3) == 0;
            y = ($urandom % 100) < pct;
            cycle("rand", h, b, r, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
